asic_ioctrl_seq: RTL and testbench



---
 rtl/asic_ioctrl_seq.sv | 199 +++++++++++++++++++
 tb/tb_asic_ioctrl_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asic_ioctrl_seq.sv
// ---------------------------------------------------------------------------
// asic_ioctrl_seq
//
// Power-sequencing controller for the padring control ring. On power-up it
// raises the NCTRL control lines one at a time (thermometer order from bit 0).
// Each step waits a programmable settle delay and the matching sense
// acknowledge. On power-down the lines are released in reverse order. A
// missing acknowledge (timeout) or loss of sense while fully up latches a
// fault and drops the whole ring at once.
//
// Ports:
//   clk          clock
//   reset        synchronous active-high reset
//   on_req       request power-up (level or pulse)
//   off_req      request power-down (level or pulse); wins over on_req in OFF
//   clear_fault  pulse; leaves FAULT back to OFF
//   delay        settle cycles per step, 0 behaves as 1
//   sense        per-line acknowledge from the ring, already synchronized
//   ctrl         ring enables, thermometer-coded from bit 0 (registered)
//   ready        high while fully powered (ON)
//   busy         high while stepping (UP or DOWN)
//   fault        high while in FAULT
//   fault_idx    line that caused the last fault (registered)
// ---------------------------------------------------------------------------
module asic_ioctrl_seq #(
    parameter int NCTRL   = 8,
    parameter int CW      = 16,
    parameter int TIMEOUT = 1000,
    localparam int IW     = (NCTRL > 1) ? $clog2(NCTRL) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             on_req,
    input  logic             off_req,
    input  logic             clear_fault,
    input  logic [CW-1:0]    delay,
    input  logic [NCTRL-1:0] sense,
    output logic [NCTRL-1:0] ctrl,
    output logic             ready,
    output logic             busy,
    output logic             fault,
    output logic [IW-1:0]    fault_idx
);

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_UP    = 3'd1;
    localparam logic [2:0] ST_ON    = 3'd2;
    localparam logic [2:0] ST_DOWN  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [IW-1:0] LAST_IDX  = IW'(NCTRL - 1);

    logic [2:0]       state_q,     state_d;
    logic [NCTRL-1:0] ctrl_q,      ctrl_d;
    logic [IW-1:0]    idx_q,       idx_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [IW-1:0]    fault_idx_q, fault_idx_d;

    logic [CW-1:0]    eff_delay;
    logic [CW-1:0]    cnt_inc;
    logic             settled;
    logic [IW-1:0]    next_idx;
    logic [IW-1:0]    low_idx;

    // A zero delay still needs one settle cycle so every step is observable.
    assign eff_delay = (delay == '0) ? CW'(1) : delay;
    // The counter saturates instead of wrapping, so a long delay can never
    // alias back to a small count.
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    assign settled   = (cnt_q >= eff_delay);
    assign next_idx  = idx_q + IW'(1);

    // Lowest sense line that is low; scanning downward lets the lowest hit
    // overwrite any higher one.
    always_comb begin
        low_idx = '0;
        for (int i = NCTRL - 1; i >= 0; i--) begin
            if (!sense[i]) begin
                low_idx = IW'(i);
            end
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        fault_idx_d = fault_idx_q;

        case (state_q)
            ST_OFF: begin
                ctrl_d = '0;
                idx_d  = '0;
                cnt_d  = '0;
                if (on_req && !off_req) begin
                    state_d = ST_UP;
                    ctrl_d  = NCTRL'(1);
                end
            end

            ST_UP: begin
                // Timeout and advance are mutually exclusive (sense low vs
                // high). A timeout is handled ahead of an abort so a dead line
                // is always reported.
                if (cnt_q == TIMEOUT_C && !sense[idx_q]) begin
                    state_d     = ST_FAULT;
                    ctrl_d      = '0;
                    fault_idx_d = idx_q;
                end else if (off_req) begin
                    // Release starts from the line currently being raised.
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else if (settled && sense[idx_q]) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_ON;
                    end else begin
                        idx_d            = next_idx;
                        ctrl_d[next_idx] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_ON: begin
                // Sense loss has priority over a simultaneous off request.
                if (!(&sense)) begin
                    state_d     = ST_FAULT;
                    ctrl_d      = '0;
                    fault_idx_d = low_idx;
                end else if (off_req) begin
                    state_d = ST_DOWN;
                    idx_d   = LAST_IDX;
                    cnt_d   = '0;
                end
            end

            ST_DOWN: begin
                // Release is open-loop: sense is not checked on the way down.
                if (settled) begin
                    ctrl_d[idx_q] = 1'b0;
                    cnt_d         = '0;
                    if (idx_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_FAULT: begin
                ctrl_d = '0;
                if (clear_fault) begin
                    state_d = ST_OFF;
                end
            end

            default: begin
                state_d = ST_OFF;
                ctrl_d  = '0;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_OFF;
            ctrl_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            fault_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            fault_idx_q <= fault_idx_d;
        end
    end

    assign ctrl      = ctrl_q;
    assign fault_idx = fault_idx_q;
    assign ready     = (state_q == ST_ON);
    assign busy      = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_asic_ioctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_asic_ioctrl_seq
//
// Bench for asic_ioctrl_seq. A reference model tracks the ring as a number
// of powered lines plus a wait timer, and every cycle all outputs are
// compared against it. The ring itself is emulated: sense follows the
// expected ctrl with a configurable latency, with optional forced-low bits
// for stuck lines and glitches. Directed scenarios come first, then random
// traffic.
// ---------------------------------------------------------------------------
module tb_asic_ioctrl_seq;

    localparam int NCTRL   = 8;
    localparam int CW      = 16;
    localparam int TIMEOUT = 20;
    localparam int IW      = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             on_req;
    logic             off_req;
    logic             clear_fault;
    logic [CW-1:0]    delay;
    logic [NCTRL-1:0] sense;
    logic [NCTRL-1:0] ctrl;
    logic             ready;
    logic             busy;
    logic             fault;
    logic [IW-1:0]    fault_idx;

    always #5 clk = ~clk;

    asic_ioctrl_seq #(
        .NCTRL   (NCTRL),
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .on_req      (on_req),
        .off_req     (off_req),
        .clear_fault (clear_fault),
        .delay       (delay),
        .sense       (sense),
        .ctrl        (ctrl),
        .ready       (ready),
        .busy        (busy),
        .fault       (fault),
        .fault_idx   (fault_idx)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {P_OFF, P_RAMP_UP, P_HOLD, P_RAMP_DOWN, P_TRIPPED} phase_t;

    phase_t m_phase = P_OFF;
    int     m_lvl   = 0;   // number of lines powered
    int     m_tmr   = 0;   // cycles spent waiting on the current step
    int     m_fidx  = 0;

    task automatic model_step();
        int  eff;
        int  line;
        bool_found: begin end
        eff = (delay == 0) ? 1 : int'(delay);
        if (reset) begin
            m_phase = P_OFF;
            m_lvl   = 0;
            m_tmr   = 0;
            m_fidx  = 0;
        end else begin
            case (m_phase)
                P_OFF: begin
                    if (on_req && !off_req) begin
                        m_phase = P_RAMP_UP;
                        m_lvl   = 1;
                        m_tmr   = 0;
                    end
                end
                P_RAMP_UP: begin
                    line = m_lvl - 1;
                    if (m_tmr == TIMEOUT && !sense[line]) begin
                        m_phase = P_TRIPPED;
                        m_fidx  = line;
                        m_lvl   = 0;
                    end else if (off_req) begin
                        m_phase = P_RAMP_DOWN;
                        m_tmr   = 0;
                    end else if (m_tmr >= eff && sense[line]) begin
                        m_tmr = 0;
                        if (m_lvl == NCTRL) m_phase = P_HOLD;
                        else                m_lvl   = m_lvl + 1;
                    end else if (m_tmr < CNT_MAX) begin
                        m_tmr = m_tmr + 1;
                    end
                end
                P_HOLD: begin
                    if (sense != {NCTRL{1'b1}}) begin
                        int first = -1;
                        for (int i = 0; i < NCTRL; i++) begin
                            if (!sense[i] && first < 0) first = i;
                        end
                        m_phase = P_TRIPPED;
                        m_fidx  = first;
                        m_lvl   = 0;
                    end else if (off_req) begin
                        m_phase = P_RAMP_DOWN;
                        m_tmr   = 0;
                    end
                end
                P_RAMP_DOWN: begin
                    if (m_tmr >= eff) begin
                        m_lvl = m_lvl - 1;
                        m_tmr = 0;
                        if (m_lvl == 0) m_phase = P_OFF;
                    end else if (m_tmr < CNT_MAX) begin
                        m_tmr = m_tmr + 1;
                    end
                end
                P_TRIPPED: begin
                    if (clear_fault) m_phase = P_OFF;
                end
                default: m_phase = P_OFF;
            endcase
        end
    endtask

    function automatic logic [NCTRL-1:0] lvl_mask(input int lvl);
        logic [63:0] m;
        m = (64'd1 << lvl) - 64'd1;
        return m[NCTRL-1:0];
    endfunction

    // ---------------- ring emulation ----------------
    logic [NCTRL-1:0] hist [0:3];
    int               lat       = 1;
    logic [NCTRL-1:0] force_low = '0;

    task automatic drive_sense();
        sense = hist[lat] & ~force_low;
    endtask

    // One clock: advance the model on the inputs the DUT is about to sample,
    // then compare every output just after the edge.
    task automatic tick();
        logic [NCTRL-1:0] exp_ctrl;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        exp_ctrl = lvl_mask(m_lvl);
        check("ctrl",      32'(ctrl),      32'(exp_ctrl));
        check("ready",     32'(ready),     32'(m_phase == P_HOLD));
        check("busy",      32'(busy),      32'(m_phase == P_RAMP_UP || m_phase == P_RAMP_DOWN));
        check("fault",     32'(fault),     32'(m_phase == P_TRIPPED));
        check("fault_idx", 32'(fault_idx), 32'(m_fidx));
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = exp_ctrl;
        drive_sense();
    endtask

    task automatic pulse_on();
        on_req = 1'b1;
        tick();
        on_req = 1'b0;
    endtask

    task automatic run_until(input phase_t ph, input int lvl, input int budget, input string tag);
        int n = 0;
        while (!(m_phase == ph && m_lvl == lvl) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(m_phase == ph && m_lvl == lvl), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NCTRL-1:0] stuck;
        int               stuck_left;

        for (int i = 0; i < 4; i++) hist[i] = '0;
        reset       = 1'b1;
        on_req      = 1'b0;
        off_req     = 1'b0;
        clear_fault = 1'b0;
        delay       = CW'(3);
        sense       = '0;

        // Reset state
        tick();
        tick();
        check("rst_ctrl",  32'(ctrl),  32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        reset = 1'b0;
        tick();

        // Nominal power-up, delay 3, sense one cycle behind ctrl
        pulse_on();
        check("nom_c1", 32'(ctrl), 32'h01);
        for (int t = 2; t <= 34; t++) begin
            tick();
            case (t)
                5:  check("nom_c5",  32'(ctrl),  32'h03);
                9:  check("nom_c9",  32'(ctrl),  32'h07);
                28: check("nom_busy28", 32'(busy), 32'h1);
                29: check("nom_c29", 32'(ctrl),  32'hFF);
                32: check("nom_rdy32", 32'(ready), 32'h0);
                33: check("nom_rdy33", 32'(ready), 32'h1);
                default: ;
            endcase
        end

        // Power-down from ON, delay 2
        delay   = CW'(2);
        off_req = 1'b1;
        tick();
        off_req = 1'b0;
        check("dn_ready", 32'(ready), 32'h0);
        for (int t = 2; t <= 27; t++) begin
            tick();
            case (t)
                3:  check("dn_c3",  32'(ctrl), 32'hFF);
                4:  check("dn_c4",  32'(ctrl), 32'h7F);
                7:  check("dn_c7",  32'(ctrl), 32'h3F);
                24: check("dn_c24", 32'(ctrl), 32'h01);
                25: begin
                    check("dn_c25",    32'(ctrl), 32'h00);
                    check("dn_busy25", 32'(busy), 32'h0);
                end
                default: ;
            endcase
        end

        // Timeout on line 2
        delay     = CW'(3);
        force_low = 8'h04;
        drive_sense();
        pulse_on();
        for (int t = 2; t <= 31; t++) begin
            tick();
            case (t)
                9:  check("to_c9",  32'(ctrl), 32'h07);
                29: check("to_c29", 32'(ctrl), 32'h07);
                30: begin
                    check("to_fault", 32'(fault),     32'h1);
                    check("to_ctrl",  32'(ctrl),      32'h00);
                    check("to_idx",   32'(fault_idx), 32'h2);
                end
                default: ;
            endcase
        end
        force_low = '0;
        drive_sense();
        on_req = 1'b1;          // ignored while faulted
        tick();
        on_req = 1'b0;
        check("to_hold", 32'(fault), 32'h1);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("to_clr", 32'(fault), 32'h0);
        pulse_on();
        check("to_restart", 32'(ctrl), 32'h01);
        run_until(P_HOLD, NCTRL, 100, "wait_on");

        // Sense loss on lines 5 and 6 for one cycle
        force_low = 8'h60;
        drive_sense();
        tick();
        force_low = '0;
        drive_sense();
        check("sl_fault", 32'(fault),     32'h1);
        check("sl_ctrl",  32'(ctrl),      32'h00);
        check("sl_idx",   32'(fault_idx), 32'h5);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;

        // Abort during power-up at ctrl=0F
        delay = CW'(2);
        pulse_on();
        run_until(P_RAMP_UP, 4, 100, "wait_0f");
        check("ab_0f", 32'(ctrl), 32'h0F);
        off_req = 1'b1;
        tick();
        off_req = 1'b0;
        for (int t = 2; t <= 14; t++) begin
            tick();
            case (t)
                4:  check("ab_c4",  32'(ctrl), 32'h07);
                7:  check("ab_c7",  32'(ctrl), 32'h03);
                10: check("ab_c10", 32'(ctrl), 32'h01);
                13: begin
                    check("ab_c13",    32'(ctrl), 32'h00);
                    check("ab_busy13", 32'(busy), 32'h0);
                end
                default: ;
            endcase
        end

        // Both requests in OFF: off wins
        on_req  = 1'b1;
        off_req = 1'b1;
        tick();
        tick();
        on_req  = 1'b0;
        off_req = 1'b0;
        check("both_busy", 32'(busy), 32'h0);
        check("both_ctrl", 32'(ctrl), 32'h00);

        // Reset mid power-up at ctrl=1F
        delay = CW'(1);
        pulse_on();
        run_until(P_RAMP_UP, 5, 100, "wait_1f");
        check("rm_1f", 32'(ctrl), 32'h1F);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_ctrl", 32'(ctrl), 32'h00);
        check("rm_busy", 32'(busy), 32'h0);
        pulse_on();
        check("rm_restart", 32'(ctrl), 32'h01);

        // Random traffic
        stuck      = '0;
        stuck_left = 0;
        for (int n = 0; n < 4000; n++) begin
            on_req      = ($urandom_range(11) == 0);
            off_req     = ($urandom_range(29) == 0);
            clear_fault = ($urandom_range(14) == 0);
            reset       = ($urandom_range(799) == 0);
            if ($urandom_range(59) == 0) delay = CW'($urandom_range(7));
            if ($urandom_range(299) == 0) lat = 1 + $urandom_range(2);
            if (stuck_left > 0) begin
                stuck_left--;
            end else begin
                stuck = '0;
                if ($urandom_range(399) == 0) begin
                    stuck      = NCTRL'(1) << $urandom_range(NCTRL - 1);
                    stuck_left = 60;
                end
            end
            force_low = stuck;
            if ($urandom_range(79) == 0) force_low = force_low | NCTRL'($urandom);
            drive_sense();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
